// File: rtl/bound_flasher_param.sv
// Bound-flasher controller: one flick runs a thermometer lamp bar through an up/down bounce with kickback.
// Optional end-of-sequence blink phase is compiled in with `define BF_BLINK_EN.
module bound_flasher_param #(
  parameter int N_LAMPS     = 16,
  parameter int B1          = 5,
  parameter int B2          = 10,
  parameter int STEP_DIV    = 1,
  parameter int BLINK_COUNT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flick,
  output logic [N_LAMPS-1:0] lamps,
  output logic [2:0]         state,
  output logic               busy
);
  localparam int CW = $clog2(N_LAMPS + 1);
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0, UP1 = 3'd1, DN1 = 3'd2, UP2 = 3'd3,
    DN2 = 3'd4, UP3 = 3'd5, DN3 = 3'd6, BLINK = 3'd7
  } st_t;

  generate
    if (N_LAMPS < 4 || B1 <= 0 || B2 <= B1 || B2 >= N_LAMPS - 1 ||
        STEP_DIV < 1 || BLINK_COUNT < 1) begin : g_bad_params
      $fatal(1, "bound_flasher_param: illegal parameter combination");
    end
  endgenerate

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_B1  = CW'(B1);
  localparam logic [CW-1:0] C_B1P = CW'(B1 + 1);
  localparam logic [CW-1:0] C_B2P = CW'(B2 + 1);
  localparam logic [CW-1:0] C_N   = CW'(N_LAMPS);
  localparam logic [PW-1:0] P_END = PW'(STEP_DIV - 1);

  st_t           st;
  logic [CW-1:0] c, c_up, c_dn;
  logic [PW-1:0] presc;
  logic          tick, kick;

  assign tick  = (presc == P_END);
  assign c_up  = c + C_ONE;
  assign c_dn  = c - C_ONE;
  // Kickback qualifies only on steps that light a bound lamp.
  assign kick  = flick && (c_up == C_B1P || c_up == C_B2P);
  assign state = st;
  assign busy  = (st != IDLE);

  function automatic logic [N_LAMPS-1:0] therm(input logic [CW-1:0] n);
    logic [N_LAMPS-1:0] t;
    for (int i = 0; i < N_LAMPS; i++) t[i] = (i < int'(n));
    return t;
  endfunction

`ifdef BF_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [BW-1:0] B_LAST = BW'(2 * BLINK_COUNT - 1);
  logic [BW-1:0] bcnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= IDLE;
      c     <= '0;
      presc <= '0;
      lamps <= '0;
`ifdef BF_BLINK_EN
      bcnt  <= '0;
`endif
    end else if (st == IDLE) begin
      if (flick) begin
        st    <= UP1;
        c     <= C_ONE;
        lamps <= therm(C_ONE);
        presc <= '0;
      end
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        case (st)
          UP1: begin
            c <= c_up; lamps <= therm(c_up);
            if (c_up == C_B1P) st <= DN1;
          end
          DN1: begin
            c <= c_dn; lamps <= therm(c_dn);
            if (c_dn == '0) st <= UP2;
          end
          UP2: begin
            c <= c_up; lamps <= therm(c_up);
            if (kick)                st <= DN1;
            else if (c_up == C_B2P)  st <= DN2;
          end
          DN2: begin
            c <= c_dn; lamps <= therm(c_dn);
            if (c_dn == C_B1) st <= UP3;
          end
          UP3: begin
            c <= c_up; lamps <= therm(c_up);
            if (kick)               st <= DN2;
            else if (c_up == C_N)   st <= DN3;
          end
          DN3: begin
            c <= c_dn; lamps <= therm(c_dn);
            if (c_dn == '0) begin
`ifdef BF_BLINK_EN
              st   <= BLINK;
              bcnt <= '0;
`else
              st   <= IDLE;
`endif
            end
          end
`ifdef BF_BLINK_EN
          BLINK: begin
            // Even number of toggles, so the bar ends dark.
            lamps <= ~lamps;
            bcnt  <= bcnt + BW'(1);
            if (bcnt == B_LAST) st <= IDLE;
          end
`endif
          default: begin
            st    <= IDLE;
            c     <= '0;
            lamps <= '0;
          end
        endcase
      end
    end
  end
endmodule
